cart_unlock_host: RTL
=====================

Name: cart_unlock_host

Overview:
Console-side counterpart of the cartridge mapper's unlock/serial handshake. On a start request it drives the two-address unlock sequence (5Ah then A5h) onto the cartridge address bus. It then receives the 18-bit synchronous bitstream the mapper returns on SO, checks framing, and compares the payload to the expected key. On success it sets SYSTEM_CTRL1 bit 7 (cart_ok), which the boot ROM / system-control block consumes.

Parameters:
EXPECT, 16'h28A0, payload the cartridge must return (LSB first).
HUNT_TIMEOUT, 8, max SO samples in HUNT waiting for the start bit; must be >= 1.
ADDR_ACK, 8'h5A, first unlock address.
ADDR_NAK, 8'hA5, second unlock address.
ADDR_IDLE, 8'hFF, address driven when not unlocking.

Ports:
CLK  in  1  system clock; cartridge mapper shares this clock.
RSTn  in  1  synchronous active-low reset.
start  in  1  one-cycle request to run the unlock sequence; ignored while busy.
SO  in  1  serial data from cartridge; idles high.
ADDR  out  8  cartridge address byte (A-1..A3, A15..A18 packing).
ADDR_OE  out  1  high while ADDR carries an unlock address.
busy  out  1  high from the cycle after start is accepted until DONE/FAIL.
done  out  1  sticky; set on entering DONE or FAIL, cleared on accepted start.
pass  out  1  sticky; set on entering DONE, cleared on accepted start.
err  out  2  0 = none, 1 = start-bit timeout, 2 = framing (stop bit 1), 3 = payload mismatch; cleared on accepted start.
rx_data  out  16  last received payload.
ctrl1_b7  out  1  SYSTEM_CTRL1 bit 7; set on pass, cleared only by RSTn.

Behaviour:
- All outputs registered.
- Reset (RSTn low at a CLK edge): state IDLE, ADDR = ADDR_IDLE, ADDR_OE = 0, busy/done/pass = 0, err = 0, rx_data = 0, ctrl1_b7 = 0, counters = 0.
- States: IDLE, ACK, NAK, HUNT, DATA, STOP, DONE, FAIL. DONE and FAIL behave as IDLE with result flags held.
- IDLE/DONE/FAIL, start = 1 at edge e0:
  - go to ACK; ADDR = 5Ah, ADDR_OE = 1, busy = 1.
  - clear done, pass and err; rx_data is retained.
- ACK, edge e1: the cartridge samples 5Ah. Go to NAK; ADDR = A5h.
- NAK, edge e2: the cartridge loads its shift register. Go to HUNT; ADDR = ADDR_IDLE, ADDR_OE = 0, hunt_cnt = 0.
- HUNT, each edge, sample SO:
  - SO = 0: start bit; go to DATA, bit_cnt = 0.
  - else if hunt_cnt == HUNT_TIMEOUT-1: go to FAIL, err = 1.
  - else hunt_cnt++.
  - With a compliant cartridge the start bit is sampled at e3.
- DATA, each edge: shift right, rx_data = {SO, rx_data[15:1]}, bit_cnt++. After 16 samples (bit_cnt == 15) go to STOP. Nominal data edges are e4..e19.
- STOP, edge e20, sample SO:
  - SO = 1: FAIL, err = 2.
  - SO = 0 and rx_data == EXPECT: DONE, pass = 1, ctrl1_b7 = 1.
  - SO = 0 and rx_data != EXPECT: FAIL, err = 3.
- Entering DONE/FAIL: done = 1, busy = 0 on the same edge. Nominal pass is visible after e20, i.e. 21 cycles after start.
- start while busy: ignored, no restart.
- RSTn low mid-sequence: immediate return to reset values at that edge, including ctrl1_b7.
- Re-run after a pass: the cartridge is locked and no longer answers, so the run ends in FAIL with err = 1. ctrl1_b7 stays 1.
- SO is sampled directly (same clock domain, no synchroniser). An SO of X/Z is treated as 1 in HUNT only by the bench model; the RTL takes no special action.
- Counters: hunt_cnt is clog2(HUNT_TIMEOUT)+1 bits; bit_cnt is 4 bits. Neither wraps within a run.

Test Plan:
- Nominal: after reset, pulse start. The bench cartridge model returns {0, 28A0h LSB-first, 0} starting at e3 -> ADDR = 5Ah at e0..e1, A5h at e1..e2, then FFh. After e20: pass = 1, done = 1, err = 0, rx_data = 28A0h, ctrl1_b7 = 1, busy = 0.
- Timeout: SO held 1 -> after 8 HUNT samples (edge e10): done = 1, pass = 0, err = 1, ctrl1_b7 = 0.
- Framing: model returns correct payload but stop bit 1 -> err = 2, pass = 0, rx_data = 28A0h.
- Mismatch / late start: model sends payload 28A1h -> err = 3. A separate run with the start bit delayed 3 cycles (sampled at e6) -> pass = 1.
- Busy and lock: a second start pulse at e5 is ignored (same e20 completion). Re-running start after a pass gives err = 1 with ctrl1_b7 still 1.
- Reset mid-run: RSTn low at e12 -> all outputs return to reset values at that edge, including ctrl1_b7 = 0. A following start completes normally.

Source files
------------

// File: rtl/cart_unlock_host.sv
// Console-side unlock host for the cartridge mapper: drives the 5Ah/A5h
// unlock addresses, receives the 18-bit framed reply on SO, checks the
// payload against EXPECT and latches SYSTEM_CTRL1 bit 7 on success.
module cart_unlock_host #(
   parameter logic [15:0] EXPECT       = 16'h28A0,
   parameter int unsigned HUNT_TIMEOUT = 8,
   parameter logic [7:0]  ADDR_ACK     = 8'h5A,
   parameter logic [7:0]  ADDR_NAK     = 8'hA5,
   parameter logic [7:0]  ADDR_IDLE    = 8'hFF
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        start,
   input  logic        SO,
   output logic [7:0]  ADDR,
   output logic        ADDR_OE,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [1:0]  err,
   output logic [15:0] rx_data,
   output logic        ctrl1_b7
);

   localparam int unsigned HW = $clog2(HUNT_TIMEOUT) + 1;
   localparam logic [HW-1:0] HUNT_LAST = HW'(HUNT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ACK,
      NAK,
      HUNT,
      DATA,
      STOP,
      DONE,
      FAIL
   } state_t;

   state_t          state;
   logic [HW-1:0]   hunt_cnt;
   logic [3:0]      bit_cnt;

   // Unlock sequencer, serial receiver and result flags in one registered FSM.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state    <= IDLE;
         ADDR     <= ADDR_IDLE;
         ADDR_OE  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err      <= 2'd0;
         rx_data  <= '0;
         ctrl1_b7 <= 1'b0;
         hunt_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            IDLE, DONE, FAIL: begin
               if (start) begin
                  state   <= ACK;
                  ADDR    <= ADDR_ACK;
                  ADDR_OE <= 1'b1;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  err     <= 2'd0;
               end
            end
            ACK: begin
               state <= NAK;
               ADDR  <= ADDR_NAK;
            end
            NAK: begin
               state    <= HUNT;
               ADDR     <= ADDR_IDLE;
               ADDR_OE  <= 1'b0;
               hunt_cnt <= '0;
            end
            HUNT: begin
               if (!SO) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end else if (hunt_cnt == HUNT_LAST) begin
                  state <= FAIL;
                  err   <= 2'd1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  hunt_cnt <= hunt_cnt + HW'(1);
               end
            end
            DATA: begin
               rx_data <= {SO, rx_data[15:1]};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd15) begin
                  state <= STOP;
               end
            end
            STOP: begin
               done <= 1'b1;
               busy <= 1'b0;
               if (SO) begin
                  state <= FAIL;
                  err   <= 2'd2;
               end else if (rx_data == EXPECT) begin
                  state    <= DONE;
                  pass     <= 1'b1;
                  ctrl1_b7 <= 1'b1;
               end else begin
                  state <= FAIL;
                  err   <= 2'd3;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
